// File: rtl/count_seq_ctrl.sv
// Sequencing controller for the 4-bit up counter: programmable period timer with
// start/pause/resume/stop, one-shot or auto-reload. Optional prescaler via CTRL_PRESCALE_EN.
module count_seq_ctrl #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DEFAULT_PERIOD = 9,
  parameter int unsigned PRESCALE       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  // Terminal value of the current run; latched on start so a concurrent cfg write waits.
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;
  logic             launch;

  assign launch = ((state_q == StIdle) || (state_q == StDone)) && start && !stop;

`ifdef CTRL_PRESCALE_EN
  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PscW-1:0] psc_q, psc_d;

  assign step = (state_q == StRun) && (psc_q == PscW'(PRESCALE - 1));

  always_comb begin
    psc_d = psc_q;
    if (launch) begin
      psc_d = '0;
    end else if (state_q == StRun && !stop) begin
      psc_d = step ? '0 : psc_q + 1'b1;
    end else if (state_q == StHold && stop) begin
      psc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign step = (state_q == StRun);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    term_d   = term_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (cfg_valid && cfg_ready) begin
      period_d = cfg_period;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (launch) begin
          state_d = StRun;
          count_d = '0;
          mode_d  = mode;
          term_d  = period_q;
          done_d  = 1'b0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StHold;
        end else if (step) begin
          if (count_q == term_q) begin
            tc_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              // One-shot: count stays parked at the terminal value.
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      term_q   <= WIDTH'(DEFAULT_PERIOD);
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      term_q   <= term_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign done      = done_q;
  assign busy      = (state_q == StRun) || (state_q == StHold);
  assign cfg_ready = (state_q == StIdle) || (state_q == StDone);

endmodule
